// File: rtl/otp_lci_macro_rsp.sv
// OTP macro responder: grants native OTP commands and serves 16-bit
// program-once words with configurable grant/response latency.
module otp_lci_macro_rsp #(
  parameter int NumWords   = 44,
  parameter int BaseAddr   = 0,
  parameter int AddrWidth  = 10,
  parameter int GntLatency = 1,
  parameter int RspLatency = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic [2:0]           cmd_i,
  input  logic [1:0]           size_i,
  input  logic [63:0]          wdata_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [2:0]           err_inj_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [63:0]          rdata_o,
  output logic [2:0]           err_o,
  output logic                 idle_o
);

  localparam int AW1  = AddrWidth + 1;
  localparam int IdxW = $clog2(NumWords);

  localparam logic [2:0] CmdRead  = 3'd0;
  localparam logic [2:0] CmdWrite = 3'd1;
  localparam logic [2:0] ErrMacro = 3'd1;
  localparam logic [2:0] ErrBlank = 3'd4;

  localparam logic [2:0] GntLoad  =
    (GntLatency > 0) ? 3'(GntLatency - 1) : 3'd0;
  localparam logic [2:0] BusyLoad =
    (RspLatency > 1) ? 3'(RspLatency - 2) : 3'd0;

  typedef enum logic [1:0] {
    IdleSt, GntWaitSt, BusySt, RspSt
  } state_e;

  typedef struct packed {
    logic [2:0]           cmd;
    logic [1:0]           size;
    logic [AddrWidth-1:0] addr;
    logic [63:0]          wdata;
    logic [2:0]           inj;
  } req_t;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  req_t       req_q, req_d;
  logic       rvalid_q, rvalid_d;
  logic [63:0] rdata_q, rdata_d;
  logic [2:0] err_q, err_d;
  logic [15:0] mem_q [NumWords];
  logic [15:0] mem_d [NumWords];
  logic       gnt, exec;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IdleSt;
      cnt_q    <= '0;
      req_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= '0;
      for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      for (int i = 0; i < NumWords; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    exec    = 1'b0;
    unique case (state_q)
      IdleSt: begin
        if (req_i) begin
          if (GntLatency == 0) begin
            gnt = 1'b1;
          end else begin
            cnt_d   = GntLoad;
            state_d = GntWaitSt;
          end
        end
      end
      GntWaitSt: begin
        if (cnt_q == 3'd0) gnt = 1'b1;
        else cnt_d = cnt_q - 3'd1;
      end
      BusySt: begin
        if (cnt_q == 3'd0) begin
          exec    = 1'b1;
          state_d = RspSt;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RspSt:   state_d = IdleSt;
      default: state_d = IdleSt;
    endcase
    // A one-cycle response latency executes on the grant cycle itself
    if (gnt) begin
      if (RspLatency == 1) begin
        exec    = 1'b1;
        state_d = RspSt;
      end else begin
        cnt_d   = BusyLoad;
        state_d = BusySt;
      end
    end
  end

  always_comb begin
    logic [AW1-1:0]  idx, last_idx;
    logic [IdxW-1:0] widx;
    logic [15:0]     wk;
    logic            in_range, illegal, blank;
    req_d    = gnt ? req_t'{cmd_i, size_i, addr_i, wdata_i, err_inj_i}
                   : req_q;
    mem_d    = mem_q;
    rvalid_d = exec;
    rdata_d  = '0;
    err_d    = '0;
    widx     = '0;
    wk       = '0;
    blank    = 1'b0;
    idx      = AW1'(req_d.addr) - AW1'(BaseAddr);
    last_idx = idx + AW1'(req_d.size);
    in_range = (AW1'(req_d.addr) >= AW1'(BaseAddr)) &&
               (last_idx < AW1'(NumWords));
    illegal  = (req_d.cmd != CmdRead) && (req_d.cmd != CmdWrite);
    if (exec && in_range && !illegal) begin
      for (int k = 0; k < 4; k++) begin
        if (k <= int'(req_d.size)) begin
          widx = IdxW'(idx + AW1'(k));
          wk   = req_d.wdata[16*k +: 16];
          if (req_d.cmd == CmdWrite) begin
            blank       = blank | (|(mem_q[widx] & ~wk));
            mem_d[widx] = mem_q[widx] | wk;
          end else begin
            rdata_d[16*k +: 16] = mem_q[widx];
          end
        end
      end
    end
    if (exec) begin
      if (illegal || !in_range) err_d = ErrMacro;
      else if (req_d.inj != 3'd0) err_d = req_d.inj;
      else if (blank) err_d = ErrBlank;
    end
  end

  assign gnt_o    = gnt;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign idle_o   = (state_q == IdleSt);

endmodule

// File: tb/tb_otp_lci_macro_rsp.sv
// Directed bench for otp_lci_macro_rsp: defaults instance plus two
// latency-sweep instances sharing the command fields.
module tb_otp_lci_macro_rsp;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_i, req_a, req_b;
  logic [2:0]  cmd;
  logic [1:0]  size;
  logic [63:0] wdata;
  logic [9:0]  addr;
  logic [2:0]  inj;

  logic        gnt_o, rvalid_o, idle_o;
  logic [63:0] rdata_o;
  logic [2:0]  err_o;
  logic        gnt_a, rv_a, idle_a;
  logic [63:0] rd_a;
  logic [2:0]  err_a;
  logic        gnt_b, rv_b, idle_b;
  logic [63:0] rd_b;
  logic [2:0]  err_b;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  otp_lci_macro_rsp dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .cmd_i(cmd),
    .size_i(size), .wdata_i(wdata), .addr_i(addr), .err_inj_i(inj),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .idle_o(idle_o)
  );

  otp_lci_macro_rsp #(.GntLatency(0), .RspLatency(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_a), .cmd_i(cmd),
    .size_i(size), .wdata_i(wdata), .addr_i(addr), .err_inj_i(inj),
    .gnt_o(gnt_a), .rvalid_o(rv_a), .rdata_o(rd_a),
    .err_o(err_a), .idle_o(idle_a)
  );

  otp_lci_macro_rsp #(.GntLatency(3), .RspLatency(5)) dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_b), .cmd_i(cmd),
    .size_i(size), .wdata_i(wdata), .addr_i(addr), .err_inj_i(inj),
    .gnt_o(gnt_b), .rvalid_o(rv_b), .rdata_o(rd_b),
    .err_o(err_b), .idle_o(idle_b)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic [2:0] c, input logic [1:0] s,
                     input logic [9:0] a, input logic [63:0] w,
                     input logic [2:0] ij,
                     output logic [63:0] rd, output logic [2:0] e,
                     output int g, output int rv);
    int t0;
    bit got;
    @(posedge clk); #1;
    cmd = c; size = s; addr = a; wdata = w; inj = ij; req_i = 1'b1;
    t0 = cyc; g = -1; rv = -1; got = 1'b0; rd = '0; e = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt_o) g = cyc - t0;
      if (rvalid_o) begin
        got = 1'b1; rv = cyc - t0; rd = rdata_o; e = err_o;
      end
      @(posedge clk); #1;
      if (g >= 0) begin req_i = 1'b0; inj = '0; end
    end
    chk("rsp_timeout", 64'(got), 64'd1);
  endtask

  task automatic wr(string tag, logic [9:0] a, logic [1:0] s,
                    logic [63:0] w, logic [2:0] ij, logic [2:0] ee);
    logic [63:0] rd;
    logic [2:0]  e;
    int g, rv;
    txn(3'd1, s, a, w, ij, rd, e, g, rv);
    chk({tag, "_err"}, 64'(e), 64'(ee));
  endtask

  task automatic rdw(string tag, logic [9:0] a, logic [1:0] s,
                     logic [63:0] exp, logic [2:0] ee);
    logic [63:0] rd;
    logic [2:0]  e;
    int g, rv;
    txn(3'd0, s, a, 64'd0, 3'd0, rd, e, g, rv);
    chk({tag, "_err"}, 64'(e), 64'(ee));
    chk({tag, "_data"}, rd, exp);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i = 1'b0; req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    logic [63:0] rd, exp;
    logic [2:0]  e;
    int g, rv, t0, r, nrv;
    bit seen;
    rst_ni = 1'b0;
    req_i = 1'b0; req_a = 1'b0; req_b = 1'b0;
    cmd = '0; size = '0; wdata = '0; addr = '0; inj = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_rvalid", 64'(rvalid_o), 64'd0);
    chk("rst_rdata", rdata_o, 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_idle", 64'(idle_o), 64'd1);
    @(posedge clk); #1 rst_ni = 1'b1;

    txn(3'd1, 2'd0, 10'd0, 64'hA5A5, 3'd0, rd, e, g, rv);
    chk("w0_gnt_ofs", 64'(g), 64'd1);
    chk("w0_rv_ofs", 64'(rv), 64'd3);
    chk("w0_err", 64'(e), 64'd0);
    chk("w0_rdata", rd, 64'd0);
    rdw("r0", 10'd0, 2'd0, 64'h0000_0000_0000_A5A5, 3'd0);

    wr("w3a", 10'd3, 2'd0, 64'h00FF, 3'd0, 3'd0);
    wr("w3b", 10'd3, 2'd0, 64'h0F00, 3'd0, 3'd4);
    rdw("r3", 10'd3, 2'd0, 64'h0FFF, 3'd0);
    wr("w3c", 10'd3, 2'd0, 64'h0FFF, 3'd0, 3'd0);

    do_reset();
    for (int i = 0; i < 44; i++) begin
      wr("lci_w", 10'(i), 2'd0, 64'(16'(16'h1000 + i)),
         (i == 10) ? 3'd2 : 3'd0, (i == 10) ? 3'd2 : 3'd0);
    end
    for (int j = 0; j < 11; j++) begin
      exp = '0;
      for (int k = 0; k < 4; k++)
        exp[16*k +: 16] = 16'(16'h1000 + 4*j + k);
      rdw("lci_r", 10'(4*j), 2'd3, exp, 3'd0);
    end

    wr("rng_w", 10'd42, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 3'd1);
    rdw("rng_r42", 10'd42, 2'd1, 64'h0000_0000_102B_102A, 3'd0);
    rdw("rng_r43", 10'd43, 2'd0, 64'h102B, 3'd0);
    rdw("rng_r44", 10'd44, 2'd0, 64'd0, 3'd1);
    rdw("rng_r1023", 10'd1023, 2'd3, 64'd0, 3'd1);
    txn(3'd2, 2'd0, 10'd1, 64'hFFFF, 3'd0, rd, e, g, rv);
    chk("ill_err", 64'(e), 64'd1);
    rdw("ill_r1", 10'd1, 2'd0, 64'h1001, 3'd0);
    wr("inj_w", 10'd2, 2'd0, 64'h0000, 3'd3, 3'd3);
    wr("mw_blank", 10'd4, 2'd1, 64'h0000_0000_F000_1004, 3'd0, 3'd4);
    rdw("mw_r", 10'd4, 2'd1, 64'h0000_0000_F005_1004, 3'd0);

    // GL0/RL1 repeats every 2 cycles, GL3/RL5 every 9
    @(posedge clk); #1;
    cmd = 3'd0; size = 2'd0; addr = 10'd0; inj = 3'd0;
    req_a = 1'b1; req_b = 1'b1; t0 = cyc;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      r = cyc - t0;
      chk("swp_a", 64'({gnt_a, rv_a}),
          64'({(r % 2) == 0, (r % 2) == 1}));
      chk("swp_b", 64'({gnt_b, rv_b}),
          64'({(r % 9) == 3, (r % 9) == 8}));
    end
    @(posedge clk); #1 req_a = 1'b0; req_b = 1'b0;
    repeat (12) @(posedge clk);

    @(posedge clk); #1;
    cmd = 3'd1; size = 2'd0; addr = 10'd5; wdata = 64'hFFFF;
    req_i = 1'b1; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (gnt_o) seen = 1'b1;
    end
    chk("mrst_gnt_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    req_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk);
    chk("mrst_gnt", 64'(gnt_o), 64'd0);
    chk("mrst_rvalid", 64'(rvalid_o), 64'd0);
    chk("mrst_rdata", rdata_o, 64'd0);
    chk("mrst_err", 64'(err_o), 64'd0);
    chk("mrst_idle", 64'(idle_o), 64'd1);
    @(posedge clk); #1 rst_ni = 1'b1;
    nrv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rvalid_o) nrv++;
    end
    chk("mrst_no_rv", 64'(nrv), 64'd0);
    rdw("mrst_r5", 10'd5, 2'd0, 64'd0, 3'd0);
    rdw("mrst_r0", 10'd0, 2'd3, 64'd0, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
